// File: rtl/serv_wb_ram_if.sv
// Instruction and data bus bundle between the SERV core and its RAM.
interface serv_wb_ram_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    modport master (
        output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack
    );

    modport slave (
        input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack
    );
endinterface

// File: rtl/serv_wb_ram.sv
// Single-ported word RAM answering both SERV buses, dbus has fixed priority,
// optional wait states before each one-cycle ack.
module serv_wb_ram #(
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned WAIT  = 0
) (
    input  logic          clk,
    input  logic          i_rst,
    serv_wb_ram_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = AW - 2;
    localparam int unsigned WORDS = DEPTH / 4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [31:0]   mem [WORDS];

    logic [1:0]    state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          gnt_d, gnt_d_n;
    logic [IW-1:0] idx, idx_n;
    logic          we, we_n;
    logic [3:0]    sel, sel_n;
    logic [31:0]   dat, dat_n;
    logic          cyc_gnt_c;

    assign cyc_gnt_c = gnt_d ? bus.i_dbus_cyc : bus.i_ibus_cyc;

    // Next-state logic; request fields are latched only when leaving IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_d_n = gnt_d;
        idx_n   = idx;
        we_n    = we;
        sel_n   = sel;
        dat_n   = dat;
        case (state)
            ST_IDLE: begin
                if (bus.i_dbus_cyc || bus.i_ibus_cyc) begin
                    gnt_d_n = bus.i_dbus_cyc;
                    idx_n   = bus.i_dbus_cyc ? bus.i_dbus_adr[AW-1:2] : bus.i_ibus_adr[AW-1:2];
                    we_n    = bus.i_dbus_cyc & bus.i_dbus_we;
                    sel_n   = bus.i_dbus_sel;
                    dat_n   = bus.i_dbus_dat;
                    if (WAIT > 0) begin
                        state_n = ST_WAIT;
                        cnt_n   = WAIT_INIT;
                    end else begin
                        state_n = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!cyc_gnt_c) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_n = ST_ACK;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_ACK:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Control state and registered outputs; read data is fetched on entry to ACK.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            gnt_d          <= 1'b0;
            idx            <= '0;
            we             <= 1'b0;
            sel            <= 4'd0;
            dat            <= 32'd0;
            bus.o_ibus_ack <= 1'b0;
            bus.o_dbus_ack <= 1'b0;
            bus.o_ibus_rdt <= 32'd0;
            bus.o_dbus_rdt <= 32'd0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            gnt_d          <= gnt_d_n;
            idx            <= idx_n;
            we             <= we_n;
            sel            <= sel_n;
            dat            <= dat_n;
            bus.o_dbus_ack <= (state_n == ST_ACK) &&  gnt_d_n;
            bus.o_ibus_ack <= (state_n == ST_ACK) && !gnt_d_n;
            if (state_n == ST_ACK) begin
                if (gnt_d_n) bus.o_dbus_rdt <= mem[idx_n];
                else         bus.o_ibus_rdt <= mem[idx_n];
            end
        end
    end

    // Byte-masked write commits at the edge that ends the ack cycle.
    always_ff @(posedge clk) begin
        if (!i_rst && state == ST_ACK && we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mem[idx][8*b +: 8] <= dat[8*b +: 8];
            end
        end
    end

    logic unused_c;
    assign unused_c = ^{bus.i_ibus_adr[31:AW], bus.i_ibus_adr[1:0],
                        bus.i_dbus_adr[31:AW], bus.i_dbus_adr[1:0]};
endmodule
